// File: rtl/mem_responder.sv
// mem_responder: word-addressed synchronous memory for the datapath.
// The request is latched in IDLE, stalled for WAIT_STATES cycles, and then
// committed in COMPLETE with a one-cycle done pulse. A preload port fills
// the array while the responder is idle.
module mem_responder #(
  parameter int AW          = 9,
  parameter int DW          = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          read,
  input  logic          write,
  input  logic [31:0]   MAR_D,
  input  logic [DW-1:0] MDRval,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [DW-1:0] mdatain,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_COMPLETE
  } state_t;

  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  state_t        state_reg;
  logic [3:0]    cnt_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] data_reg;
  logic          op_write_reg;

  // Storage is zero at power-up and is never cleared by reset.
  logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: '0};

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          prog_hit;
  logic          commit_wr;

  // Upper address bits alias onto the low AW bits and are deliberately dropped.
  logic unused_mar;
  assign unused_mar = ^MAR_D[31:AW];

  // Single write port: either a preload (idle, no strobe) or a committed write.
  // Reset blocks the commit so an aborted access never reaches the array.
  always_comb begin
    prog_hit  = (state_reg == ST_IDLE) && prog_we && !(read || write);
    commit_wr = (state_reg == ST_COMPLETE) && op_write_reg;
    mem_we    = 1'b0;
    mem_waddr = prog_addr;
    mem_wdata = prog_data;
    if (!reset) begin
      if (commit_wr) begin
        mem_we    = 1'b1;
        mem_waddr = addr_reg;
        mem_wdata = data_reg;
      end else if (prog_hit) begin
        mem_we = 1'b1;
      end
    end
  end

  // Memory array write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Access sequencer: latch request, count wait states, commit and pulse done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      addr_reg     <= '0;
      data_reg     <= '0;
      op_write_reg <= 1'b0;
      mdatain      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (read && write) begin
            err <= 1'b1;
          end else if (read ^ write) begin
            addr_reg     <= MAR_D[AW-1:0];
            data_reg     <= MDRval;
            op_write_reg <= write;
            cnt_reg      <= WS_CNT;
            busy         <= 1'b1;
            state_reg    <= (WAIT_STATES > 0) ? ST_WAIT : ST_COMPLETE;
          end
        end
        ST_WAIT: begin
          // Strobes and preload are ignored here, not queued.
          if (cnt_reg <= 4'd1) begin
            cnt_reg   <= 4'd0;
            state_reg <= ST_COMPLETE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_COMPLETE: begin
          if (!op_write_reg) begin
            mdatain <= mem[addr_reg];
          end
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and
// one with zero wait states, checked against hand-computed values.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        read, write;
  logic [31:0] mar_d, mdr_val;
  logic        prog_we;
  logic [8:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] mdatain;
  logic        busy, done, err;

  logic        read0, write0;
  logic [31:0] mar_d0, mdr_val0;
  logic [31:0] mdatain0;
  logic        busy0, done0, err0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(.AW(9), .DW(32), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write),
    .MAR_D(mar_d), .MDRval(mdr_val),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .mdatain(mdatain), .busy(busy), .done(done), .err(err)
  );

  mem_responder #(.AW(9), .DW(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .read(read0), .write(write0),
    .MAR_D(mar_d0), .MDRval(mdr_val0),
    .prog_we(1'b0), .prog_addr(9'd0), .prog_data(32'd0),
    .mdatain(mdatain0), .busy(busy0), .done(done0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [8:0] addr, input logic [31:0] data);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // mode: 0 plain, 1 change MDRval during WAIT, 2 second write during WAIT,
  // 3 reset during WAIT. Runs a fixed 8-cycle window after the request edge.
  task automatic access(input bit sel, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int mode, input logic [31:0] inj_addr,
                        input logic [31:0] inj_data,
                        output logic [31:0] rdata, output int busy_n,
                        output int done_n, output int done_at, output int err_n);
    logic        b, d, e;
    logic [31:0] md;
    rdata = 32'd0; busy_n = 0; done_n = 0; done_at = -1; err_n = 0;
    @(negedge clk);
    if (!sel) begin
      read = rd; write = wr; mar_d = addr; mdr_val = data;
    end else begin
      read0 = rd; write0 = wr; mar_d0 = addr; mdr_val0 = data;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b  = sel ? busy0 : busy;
      d  = sel ? done0 : done;
      e  = sel ? err0 : err;
      md = sel ? mdatain0 : mdatain;
      if (b) busy_n++;
      if (e) err_n++;
      if (d) begin
        done_n++;
        if (done_at < 0) begin
          done_at = i;
          rdata   = md;
        end
      end
      if (mode == 3 && i == 1) begin
        check_eq("rst_mdatain", md, 32'd0);
        check_eq("rst_busy", {31'd0, b}, 32'd0);
        check_eq("rst_done", {31'd0, d}, 32'd0);
        check_eq("rst_err", {31'd0, e}, 32'd0);
      end
      if (i == 0) begin
        read = 1'b0; write = 1'b0; read0 = 1'b0; write0 = 1'b0;
        case (mode)
          1: mdr_val = inj_data;
          2: begin write = 1'b1; mar_d = inj_addr; mdr_val = inj_data; end
          3: reset = 1'b1;
          default: ;
        endcase
      end
      if (i == 1) begin
        write = 1'b0;
        reset = 1'b0;
      end
    end
    $display("txn sel=%0d rd=%0d wr=%0d addr=0x%0h data=0x%0h mode=%0d -> rdata=0x%0h busy=%0d done=%0d at=%0d err=%0d",
             sel, rd, wr, addr, data, mode, rdata, busy_n, done_n, done_at, err_n);
  endtask

  logic [31:0] rdata;
  int busy_n, done_n, done_at, err_n;

  initial begin
    reset = 1'b1;
    read = 1'b0; write = 1'b0; mar_d = '0; mdr_val = '0;
    read0 = 1'b0; write0 = 1'b0; mar_d0 = '0; mdr_val0 = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_mdatain", mdatain, 32'd0);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_done", {31'd0, done}, 32'd0);
    check_eq("reset_err", {31'd0, err}, 32'd0);
    reset = 1'b0;

    // Preloaded read, WAIT_STATES=2: data at 3rd edge, busy 3 cycles.
    preload(9'd18, 32'h0A000012);
    access(0, 1, 0, 32'd18, 32'd0, 0, 0, 0, rdata, busy_n, done_n, done_at, err_n);
    check_eq("rd18_data", rdata, 32'h0A000012);
    check_eq("rd18_done_at", done_at, 32'd3);
    check_eq("rd18_done_n", done_n, 32'd1);
    check_eq("rd18_busy_n", busy_n, 32'd3);
    check_eq("rd18_hold", mdatain, 32'h0A000012);

    // Write 85 to 90, MDRval changes to 7 mid-access.
    access(0, 0, 1, 32'd90, 32'd85, 1, 0, 32'd7, rdata, busy_n, done_n, done_at, err_n);
    check_eq("wr90_done_n", done_n, 32'd1);
    check_eq("wr90_busy_n", busy_n, 32'd3);
    access(0, 1, 0, 32'd90, 32'd0, 0, 0, 0, rdata, busy_n, done_n, done_at, err_n);
    check_eq("rd90_data", rdata, 32'd85);

    // Simultaneous read and write: error, no access.
    preload(9'd5, 32'h000055AA);
    access(0, 1, 1, 32'd5, 32'hFFFFFFFF, 0, 0, 0, rdata, busy_n, done_n, done_at, err_n);
    check_eq("both_err_n", err_n, 32'd1);
    check_eq("both_busy_n", busy_n, 32'd0);
    check_eq("both_done_n", done_n, 32'd0);
    access(0, 1, 0, 32'd5, 32'd0, 0, 0, 0, rdata, busy_n, done_n, done_at, err_n);
    check_eq("rd5_data", rdata, 32'h000055AA);

    // Second write strobe during WAIT is dropped.
    access(0, 0, 1, 32'd10, 32'h0000A5A5, 2, 32'd11, 32'h55, rdata, busy_n, done_n, done_at, err_n);
    check_eq("wr10_done_n", done_n, 32'd1);
    access(0, 1, 0, 32'd11, 32'd0, 0, 0, 0, rdata, busy_n, done_n, done_at, err_n);
    check_eq("rd11_data", rdata, 32'd0);
    access(0, 1, 0, 32'd10, 32'd0, 0, 0, 0, rdata, busy_n, done_n, done_at, err_n);
    check_eq("rd10_data", rdata, 32'h0000A5A5);

    // Reset during WAIT of a write aborts it.
    preload(9'd3, 32'h33333333);
    access(0, 0, 1, 32'd3, 32'hDEADBEEF, 3, 0, 0, rdata, busy_n, done_n, done_at, err_n);
    check_eq("rstwr_done_n", done_n, 32'd0);
    access(0, 1, 0, 32'd3, 32'd0, 0, 0, 0, rdata, busy_n, done_n, done_at, err_n);
    check_eq("rd3_data", rdata, 32'h33333333);

    // Address aliasing with WAIT_STATES=2.
    access(0, 0, 1, 32'h205, 32'h1234, 0, 0, 0, rdata, busy_n, done_n, done_at, err_n);
    access(0, 1, 0, 32'd5, 32'd0, 0, 0, 0, rdata, busy_n, done_n, done_at, err_n);
    check_eq("alias_data", rdata, 32'h1234);

    // Same with WAIT_STATES=0: done one cycle after the request edge.
    access(1, 0, 1, 32'h205, 32'h1234, 0, 0, 0, rdata, busy_n, done_n, done_at, err_n);
    check_eq("ws0_wr_done_at", done_at, 32'd1);
    access(1, 1, 0, 32'd5, 32'd0, 0, 0, 0, rdata, busy_n, done_n, done_at, err_n);
    check_eq("ws0_rd_data", rdata, 32'h1234);
    check_eq("ws0_rd_done_at", done_at, 32'd1);
    check_eq("ws0_rd_busy_n", busy_n, 32'd1);
    check_eq("ws0_rd_done_n", done_n, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
